// File: rtl/pc_address_pkg.sv
// rtl/pc_address_pkg.sv - shared FSM, pc_enable and address_select encodings
package pc_address_pkg;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_VEC_LO = 2'd1;
  localparam logic [1:0] S_VEC_HI = 2'd2;

  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_LOAD  = 2'b01;
  localparam logic [1:0] PC_RSVD  = 2'b10;
  localparam logic [1:0] PC_INC   = 2'b11;

  localparam logic [1:0] ADDR_PC    = 2'd0;
  localparam logic [1:0] ADDR_MEM   = 2'd1;
  localparam logic [1:0] ADDR_ALU   = 2'd2;
  localparam logic [1:0] ADDR_STACK = 2'd3;

endpackage

// File: rtl/pc_address_mux.sv
// rtl/pc_address_mux.sv - combinational 4:1 16-bit address source mux
module pc_address_mux
  import pc_address_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [15:0] pc_addr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] alu_addr,
  input  logic [15:0] stack_addr,
  output logic [15:0] addr
);

  always_comb begin
    addr = pc_addr;
    case (sel)
      ADDR_PC:    addr = pc_addr;
      ADDR_MEM:   addr = mem_addr;
      ADDR_ALU:   addr = alu_addr;
      ADDR_STACK: addr = stack_addr;
      default:    addr = pc_addr;
    endcase
  end

endmodule

// File: rtl/pc_address_unit.sv
// rtl/pc_address_unit.sv - program counter, address bus mux and vector fetch FSM
// Interrupt vector fetch is enabled by defining PC_INTERRUPT_VECTOR_EN.
module pc_address_unit
  import pc_address_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic [1:0]  pc_enable,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  stack_pointer,
  input  logic [7:0]  data_in,
  input  logic        vector_req,
  input  logic        vector_nmi,
  output logic [15:0] address_out,
  output logic [15:0] pc_value,
  output logic        vector_rd,
  output logic        busy
);

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] base;
  logic [15:0] run_addr;
  logic        vector_take;

`ifdef PC_INTERRUPT_VECTOR_EN
  assign vector_take = vector_req;
`else
  logic unused_vector_inputs;
  assign unused_vector_inputs = vector_req ^ vector_nmi;
  assign vector_take = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_VEC_LO;
      pc    <= 16'h0000;
      base  <= RESET_VECTOR;
    end else if (clk_enable) begin
      case (state)
        S_RUN: begin
          if (vector_take) begin
            state <= S_VEC_LO;
            base  <= vector_nmi ? NMI_VECTOR : IRQ_VECTOR;
          end else begin
            case (pc_enable)
              PC_LOAD: pc <= memory_address;
              PC_INC:  pc <= pc + 16'd1;
              default: pc <= pc;
            endcase
          end
        end
        S_VEC_LO: begin
          pc[7:0] <= data_in;
          state   <= S_VEC_HI;
        end
        S_VEC_HI: begin
          pc[15:8] <= data_in;
          state    <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  pc_address_mux u_mux (
    .sel        (address_select),
    .pc_addr    (pc),
    .mem_addr   (memory_address),
    .alu_addr   ({8'h00, alu_result}),
    .stack_addr ({8'h01, stack_pointer}),
    .addr       (run_addr)
  );

  // rst overrides combinationally so the bus shows the reset vector before the first edge
  always_comb begin
    address_out = run_addr;
    if (rst)
      address_out = RESET_VECTOR;
    else if (state == S_VEC_LO)
      address_out = base;
    else if (state == S_VEC_HI)
      address_out = base + 16'd1;
  end

  assign pc_value  = pc;
  assign vector_rd = rst | (state != S_RUN);
  assign busy      = rst | (state != S_RUN);

endmodule

// File: doc/pc_address_unit.md
PC_ADDRESS_UNIT -- requirements
Module: pc_address_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'hFFFC, low-byte address of the reset vector.
REQ-002 SHALL have parameter NMI_VECTOR, default 16'hFFFA, low-byte address of the NMI vector.
REQ-003 SHALL have parameter IRQ_VECTOR, default 16'hFFFE, low-byte address of the IRQ vector.
REQ-004 SHALL have the following ports, one per line:
  clk  in  1  sole clock; all state changes on its rising edge.
  rst  in  1  synchronous reset, active-high.
  clk_enable  in  1  qualifies every state update.
  pc_enable  in  2  from decode: 00 hold, 01 load jump target, 10 hold (reserved), 11 increment.
  address_select  in  2  bus source: 0 PC, 1 memory_address, 2 {8'h00,alu_result}, 3 {8'h01,stack_pointer}.
  memory_address  in  16  operand address from decode.
  alu_result  in  8  ALU output used for indexed zero-page addresses.
  stack_pointer  in  8  stack pointer register value.
  data_in  in  8  data bus, sampled during vector fetch.
  vector_req  in  1  interrupt vector fetch request.
  vector_nmi  in  1  1 selects NMI vector, 0 selects IRQ vector; sampled with vector_req.
  address_out  out  16  external address bus.
  pc_value  out  16  current program counter.
  vector_rd  out  1  high while a vector byte is read; decode holds rw=1.
  busy  out  1  high outside RUN; decode stalls in S_IDLE.

Function
REQ-005 SHALL implement FSM states RUN, VEC_LO, VEC_HI.
REQ-006 SHALL advance state and registers only on rising clk with clk_enable=1; clk_enable=0 freezes all state.
REQ-007 In VEC_LO, address_out SHALL equal the selected vector base; data_in SHALL be captured into pc[7:0]; the next state SHALL be VEC_HI.
REQ-008 In VEC_HI, address_out SHALL equal the base+1; data_in SHALL be captured into pc[15:8]; the next state SHALL be RUN.
REQ-009 vector_rd and busy SHALL be 1 in VEC_LO/VEC_HI and 0 in RUN.
REQ-010 In RUN, pc_enable=11 SHALL set pc <= pc+1, modulo 2^16 (FFFF wraps to 0000).
REQ-011 In RUN, pc_enable=01 SHALL set pc <= memory_address.
REQ-012 In RUN, pc_enable 00 or 10 SHALL hold pc.
REQ-013 pc_enable SHALL be ignored in VEC_LO and VEC_HI.
REQ-014 In RUN, address_out SHALL be a combinational mux per address_select over the registered pc and current inputs; latency 0.
REQ-015 address_out SHALL show the pre-increment pc in the cycle that increments.
REQ-016 pc_value SHALL always equal the pc register.
REQ-017 Vector base SHALL be latched on entry to VEC_LO and held through VEC_HI.

Reset
REQ-018 rst=1 SHALL, on the next clk edge regardless of clk_enable, set state=VEC_LO, pc=16'h0000 and base=RESET_VECTOR.
REQ-019 Reset SHALL take priority over vector_req and pc_enable.
REQ-020 Reset asserted mid vector fetch SHALL restart at VEC_LO with RESET_VECTOR.
REQ-021 While rst=1, address_out SHALL equal RESET_VECTOR, vector_rd=1 and busy=1.

Configuration
REQ-022 Macro PC_INTERRUPT_VECTOR_EN SHALL control interrupt vector fetch.
REQ-023 With PC_INTERRUPT_VECTOR_EN defined, vector_req=1 in RUN with clk_enable=1 SHALL enter VEC_LO with base NMI_VECTOR if vector_nmi=1, else IRQ_VECTOR, and pc_enable SHALL be ignored in that cycle.
REQ-024 With PC_INTERRUPT_VECTOR_EN undefined, vector_req and vector_nmi SHALL remain as ports but be ignored, and only reset SHALL start a vector fetch.
REQ-025 vector_req asserted during VEC_LO/VEC_HI SHALL be ignored, with no queuing.

Structure
REQ-026 Package pc_address_pkg SHALL hold the FSM state encoding, the pc_enable codes (PC_HOLD, PC_LOAD, PC_INC) and the address_select codes (ADDR_PC, ADDR_MEM, ADDR_ALU, ADDR_STACK), shared with instruction_decode.
REQ-027 The block SHALL contain one sub-module, pc_address_mux: a purely combinational 4:1 16-bit address mux.

Verification
REQ-028 Reset then data_in=34 (VEC_LO), 12 (VEC_HI) -> address_out FFFC then FFFD, then RUN with pc=1234 and busy=0.
REQ-029 pc=FFFF, pc_enable=11 for one enabled cycle -> pc=0000; with clk_enable=0 in that cycle -> pc stays FFFF.
REQ-030 pc_enable=01, memory_address=C000 -> pc=C000 next cycle; address_select=2, alu_result=85 -> address_out=0085; address_select=3, stack_pointer=FD -> address_out=01FD.
REQ-031 Macro defined, RUN, vector_req=1, vector_nmi=1, data 00 then 80 -> addresses FFFA, FFFB, then pc=8000; macro undefined -> no state change.
REQ-032 rst=1 during VEC_HI of an IRQ fetch -> next cycle VEC_LO with address_out=FFFC and pc=0000.
